// File: rtl/mac_lanes_accum.sv
// mac_lanes_accum: multi-lane multiply-accumulate engine for the PE dot-product path.
// Each accepted beat multiplies NUM_LANES operand pairs, reduces the products
// through an adder tree and folds the sum into a running accumulator. One result
// is emitted per group framed by clear/last.
// The handshake is ivalid/oready upstream and ovalid/iready downstream, with full backpressure.
//
// Optional build macro: MAC_SATURATE_EN
//   defined   - the accumulator saturates at its guard width, and the result
//               is clamped to the signed ACC_WIDTH range.
//   undefined - the accumulator and the result wrap (two's complement truncation).
//
// Pipeline: S1 operand register -> S2 adder-tree register -> S3 accumulator/output.
// A last beat accepted in cycle t gives ovalid in cycle t+3 when there is no stall.
module mac_lanes_accum #(
    parameter int NUM_LANES  = 4,
    parameter int IN_WIDTH   = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int GUARD_BITS = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ivalid,
    output logic                          oready,
    input  logic [NUM_LANES*IN_WIDTH-1:0] dataa,
    input  logic [NUM_LANES*IN_WIDTH-1:0] datab,
    input  logic                          signed_mode,
    input  logic                          clear,
    input  logic                          last,
    output logic                          ovalid,
    input  logic                          iready,
    output logic [ACC_WIDTH-1:0]          result
);

    // One extra product bit lets signed and unsigned products share a signed format.
    localparam int PROD_W = 2*IN_WIDTH + 1;
    localparam int SUM_W  = PROD_W + $clog2(NUM_LANES);
    localparam int ACC_W  = ACC_WIDTH + GUARD_BITS;

    // Global advance enable: the whole pipeline moves only when the output slot is free.
    logic en;
    assign en     = ~ovalid | iready;
    assign oready = en;

    // ------------------------------------------------------------------ S1
    logic                          s1_valid;
    logic [NUM_LANES*IN_WIDTH-1:0] s1_a;
    logic [NUM_LANES*IN_WIDTH-1:0] s1_b;
    logic                          s1_signed;
    logic                          s1_clear;
    logic                          s1_last;

    // S1: capture the incoming beat; a non-accepted cycle advances as a bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_signed <= 1'b0;
            s1_clear  <= 1'b0;
            s1_last   <= 1'b0;
        end else if (en) begin
            s1_valid  <= ivalid;
            s1_a      <= dataa;
            s1_b      <= datab;
            s1_signed <= signed_mode;
            s1_clear  <= clear;
            s1_last   <= last;
        end
    end

    // Per-lane products and their reduction (combinational between S1 and S2).
    logic signed [PROD_W-1:0] ext_a [NUM_LANES];
    logic signed [PROD_W-1:0] ext_b [NUM_LANES];
    logic signed [PROD_W-1:0] prod  [NUM_LANES];
    logic signed [SUM_W-1:0]  tree_sum;

    // Extend each operand by mode, multiply, and sum the lanes as signed values.
    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            ext_a[i] = {{(PROD_W-IN_WIDTH){s1_signed & s1_a[i*IN_WIDTH + IN_WIDTH-1]}},
                        s1_a[i*IN_WIDTH +: IN_WIDTH]};
            ext_b[i] = {{(PROD_W-IN_WIDTH){s1_signed & s1_b[i*IN_WIDTH + IN_WIDTH-1]}},
                        s1_b[i*IN_WIDTH +: IN_WIDTH]};
            prod[i]  = ext_a[i] * ext_b[i];
            tree_sum = tree_sum + SUM_W'(prod[i]);
        end
    end

    // ------------------------------------------------------------------ S2
    logic                    s2_valid;
    logic signed [SUM_W-1:0] s2_sum;
    logic                    s2_clear;
    logic                    s2_last;

    // S2: register the reduced beat sum together with its framing bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_clear <= 1'b0;
            s2_last  <= 1'b0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_sum   <= tree_sum;
            s2_clear <= s1_clear;
            s2_last  <= s1_last;
        end
    end

    // ------------------------------------------------------------------ S3
    logic signed [ACC_W-1:0]     acc;
    logic signed [ACC_W-1:0]     acc_base;
    logic signed [ACC_W-1:0]     acc_next;
    logic        [ACC_WIDTH-1:0] result_next;

`ifdef MAC_SATURATE_EN
    localparam int WIDE_W = ACC_W + 1;
    logic signed [WIDE_W-1:0] acc_wide;

    // Clamp a sum carrying one extra bit back into the guarded accumulator range.
    function automatic logic signed [ACC_W-1:0] clamp_guard(input logic signed [WIDE_W-1:0] v);
        logic signed [ACC_W-1:0] r;
        if (v[WIDE_W-1] != v[WIDE_W-2]) begin
            r = v[WIDE_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            r = v[ACC_W-1:0];
        end
        return r;
    endfunction

    // Clamp the guarded accumulator to the signed ACC_WIDTH output range.
    function automatic logic [ACC_WIDTH-1:0] sat_result(input logic signed [ACC_W-1:0] v);
        logic [ACC_WIDTH-1:0] r;
        if ((&v[ACC_W-1:ACC_WIDTH-1]) || (~|v[ACC_W-1:ACC_WIDTH-1])) begin
            r = v[ACC_WIDTH-1:0];
        end else begin
            r = v[ACC_W-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
        return r;
    endfunction
`endif

    // Next accumulator value and the converted result for a last beat.
    always_comb begin
        acc_base = s2_clear ? '0 : acc;
`ifdef MAC_SATURATE_EN
        acc_wide    = WIDE_W'(acc_base) + WIDE_W'(s2_sum);
        acc_next    = clamp_guard(acc_wide);
        result_next = sat_result(acc_next);
`else
        acc_next    = acc_base + ACC_W'(s2_sum);
        result_next = acc_next[ACC_WIDTH-1:0];
`endif
    end

    // S3: accumulate valid beats; a last beat emits the result and restarts the group.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            ovalid <= 1'b0;
            result <= '0;
        end else if (en) begin
            ovalid <= s2_valid & s2_last;
            if (s2_valid) begin
                if (s2_last) begin
                    result <= result_next;
                    acc    <= '0;
                end else begin
                    acc    <= acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_lanes_accum.sv
// tb_mac_lanes_accum: randomized self-checking bench for mac_lanes_accum.
// A behavioural model sums the lane products with plain integer arithmetic and
// queues the expected group results. A monitor collects the results handed off
// by the DUT, and each test task compares them inline.
// A second instance with ACC_WIDTH=16 exercises the overflow behaviour
// (MAC_SATURATE_EN selects the expected value).
module tb_mac_lanes_accum;

    localparam int NL = 4;
    localparam int IW = 8;
    localparam int AW = 32;
    localparam int GB = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          ivalid, oready, signed_mode, clear, last, ovalid, iready;
    logic [NL*IW-1:0] dataa, datab;
    logic [AW-1:0] result;

    logic          ivalid16, oready16, signed16, clear16, last16, ovalid16, iready16;
    logic [NL*IW-1:0] dataa16, datab16;
    logic [15:0]   result16;

    int            errors = 0;
    int            checks = 0;
    longint        m_acc;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] got_q[$];

    always #5 clock = ~clock;

    mac_lanes_accum #(.NUM_LANES(NL), .IN_WIDTH(IW), .ACC_WIDTH(AW), .GUARD_BITS(GB)) dut (
        .clock(clock), .reset(reset), .ivalid(ivalid), .oready(oready),
        .dataa(dataa), .datab(datab), .signed_mode(signed_mode), .clear(clear),
        .last(last), .ovalid(ovalid), .iready(iready), .result(result));

    mac_lanes_accum #(.NUM_LANES(NL), .IN_WIDTH(IW), .ACC_WIDTH(16), .GUARD_BITS(GB)) dut16 (
        .clock(clock), .reset(reset), .ivalid(ivalid16), .oready(oready16),
        .dataa(dataa16), .datab(datab16), .signed_mode(signed16), .clear(clear16),
        .last(last16), .ovalid(ovalid16), .iready(iready16), .result(result16));

    // Collect every result that is handed off downstream.
    always @(negedge clock) begin
        if (ovalid && iready) got_q.push_back(result);
    end

    // Sum of the lane products of one beat, as a plain integer.
    function automatic longint beat_sum(input logic [NL*IW-1:0] a, input logic [NL*IW-1:0] b,
                                        input logic sm);
        longint s, av, bv;
        s = 0;
        for (int i = 0; i < NL; i++) begin
            av = sm ? longint'($signed(a[i*IW +: IW])) : longint'(a[i*IW +: IW]);
            bv = sm ? longint'($signed(b[i*IW +: IW])) : longint'(b[i*IW +: IW]);
            s  = s + av * bv;
        end
        return s;
    endfunction

    // Convert the model accumulator to the 32-bit output.
    function automatic logic [AW-1:0] to_res(input longint v);
`ifdef MAC_SATURATE_EN
        if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'h8000_0000;
`endif
        return v[AW-1:0];
    endfunction

    // Model update for one accepted beat.
    task automatic model_beat(input logic [NL*IW-1:0] a, input logic [NL*IW-1:0] b,
                              input logic sm, input logic cl, input logic la);
        longint nxt;
        nxt = (cl ? 64'sd0 : m_acc) + beat_sum(a, b, sm);
`ifdef MAC_SATURATE_EN
        if (nxt > 64'sd549755813887) nxt = 64'sd549755813887;
        if (nxt < -64'sd549755813888) nxt = -64'sd549755813888;
`endif
        if (la) begin
            exp_q.push_back(to_res(nxt));
            m_acc = 0;
        end else begin
            m_acc = nxt;
        end
    endtask

    // Present one beat until accepted (bounded), then update the model.
    task automatic send_beat(input logic [NL*IW-1:0] a, input logic [NL*IW-1:0] b,
                             input logic sm, input logic cl, input logic la);
        int   n;
        logic ok;
        n = 0;
        ok = 1'b0;
        dataa = a; datab = b; signed_mode = sm; clear = cl; last = la; ivalid = 1'b1;
        while (!ok && n < 300) begin
            @(negedge clock);
            ok = oready;
            @(posedge clock);
            #1;
            n++;
        end
        ivalid = 1'b0; clear = 1'b0; last = 1'b0;
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout: beat not accepted after %0d cycles, required acceptance", n);
        end else begin
            model_beat(a, b, sm, cl, la);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Wait (bounded) until the expected number of results has arrived, plus slack for extras.
    task automatic wait_results();
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 300) begin
            @(posedge clock);
            n++;
        end
        idle(6);
    endtask

    task automatic test_reset();
        reset = 1'b1; iready = 1'b1; ivalid = 1'b0; ivalid16 = 1'b0; iready16 = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (ovalid !== 1'b0) begin errors++; $display("FAIL reset_ovalid: got %b want 0", ovalid); end
        checks++;
        if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        reset = 1'b0;
        m_acc = 0;
        @(negedge clock);
        checks++;
        if (oready !== 1'b1) begin errors++; $display("FAIL reset_oready: got %b want 1", oready); end
        exp_q.delete(); got_q.delete();
        idle(1);
    endtask

    task automatic test_single_signed();
        exp_q.delete(); got_q.delete();
        send_beat({8'd4, 8'd3, 8'd2, 8'd1}, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            checks++;
            if (ovalid !== (k == 3)) begin
                errors++;
                $display("FAIL latency_c%0d: ovalid got %b want %b", k, ovalid, (k == 3));
            end
        end
        checks++;
        if (result !== 32'hFFFF_FFF6) begin errors++; $display("FAIL single_signed: got %h want fffffff6", result); end
        wait_results();
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            errors++; $display("FAIL single_count: got %0d want 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL single_model: got %h want %h", got_q[0], exp_q[0]); end
        end
    endtask

    task automatic test_unsigned_group();
        exp_q.delete(); got_q.delete();
        send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        // next group has no clear: it must start from zero
        send_beat($urandom, $urandom, 1'b1, 1'b0, 1'b0);
        send_beat($urandom, $urandom, 1'b0, 1'b0, 1'b1);
        wait_results();
        checks++;
        if (got_q.size() != 2) begin
            errors++; $display("FAIL unsigned_count: got %0d want 2", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 32'd780300) begin errors++; $display("FAIL unsigned_sum: got %0d want 780300", got_q[0]); end
            checks++;
            if (got_q[1] !== exp_q[1]) begin errors++; $display("FAIL next_group: got %h want %h", got_q[1], exp_q[1]); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        exp_q.delete(); got_q.delete();
        iready = 1'b0;
        send_beat($urandom, $urandom, 1'b1, 1'b1, 1'b1);
        n = 0;
        while (!ovalid && n < 20) begin @(negedge clock); n++; end
        checks++;
        if (!ovalid) begin errors++; $display("FAIL bp_pending: ovalid got 0 want 1"); end
        fork
            begin
                send_beat($urandom, $urandom, 1'b0, 1'b1, 1'b1);
                send_beat($urandom, $urandom, 1'b1, 1'b1, 1'b1);
            end
            begin
                for (int k = 0; k < 10; k++) begin
                    @(negedge clock);
                    checks++;
                    if (oready !== 1'b0 || result !== exp_q[0]) begin
                        errors++;
                        $display("FAIL bp_hold_c%0d: oready=%b result=%h want oready=0 result=%h", k, oready, result, exp_q[0]);
                    end
                end
                @(posedge clock);
                #1;
                iready = 1'b1;
            end
        join
        wait_results();
        checks++;
        if (got_q.size() != 3) begin
            errors++; $display("FAIL bp_count: got %0d want 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_order_%0d: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_bubbles();
        logic [NL*IW-1:0] a[3], b[3];
        logic             sm[3];
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 3; i++) begin a[i] = $urandom; b[i] = $urandom; sm[i] = 1'($urandom_range(0, 1)); end
        for (int i = 0; i < 3; i++) begin
            send_beat(a[i], b[i], sm[i], i == 0, i == 2);
            idle($urandom_range(1, 4));
        end
        for (int i = 0; i < 3; i++) send_beat(a[i], b[i], sm[i], i == 0, i == 2);
        wait_results();
        checks++;
        if (got_q.size() != 2) begin
            errors++; $display("FAIL bubble_count: got %0d want 2", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL bubble_gaps: got %h want %h", got_q[0], exp_q[0]); end
            checks++;
            if (got_q[1] !== got_q[0]) begin errors++; $display("FAIL bubble_nogap: got %h want %h", got_q[1], got_q[0]); end
        end
    endtask

    task automatic test_reset_mid_group();
        exp_q.delete(); got_q.delete();
        send_beat($urandom, $urandom, 1'b0, 1'b1, 1'b0);
        send_beat($urandom, $urandom, 1'b0, 1'b0, 1'b0);
        idle(1);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        m_acc = 0;
        idle(1);
        send_beat($urandom, $urandom, 1'b1, 1'b0, 1'b1);
        wait_results();
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL reset_mid_count: got %0d want 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL reset_mid_value: got %h want %h", got_q[0], exp_q[0]); end
        end
    endtask

    task automatic test_random();
        bit done;
        int len;
        exp_q.delete(); got_q.delete();
        done = 1'b0;
        fork
            begin
                for (int g = 0; g < 10; g++) begin
                    len = $urandom_range(1, 5);
                    for (int i = 0; i < len; i++) begin
                        send_beat($urandom, $urandom, 1'($urandom_range(0, 1)),
                                  (i == 0) && ($urandom_range(0, 3) != 0), i == len - 1);
                        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clock);
                    #1;
                    iready = ($urandom_range(0, 3) != 0);
                end
                iready = 1'b1;
            end
        join
        wait_results();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL random_count: got %0d want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_%0d: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_overflow();
        int          n;
        logic [15:0] want;
`ifdef MAC_SATURATE_EN
        want = 16'h7FFF;
`else
        want = 16'hB050;
`endif
        iready16 = 1'b1; signed16 = 1'b1; datab16 = {4{8'd127}};
        for (int i = 0; i < 20; i++) begin
            dataa16 = {4{8'd127}}; clear16 = (i == 0); last16 = (i == 19); ivalid16 = 1'b1;
            @(posedge clock);
            #1;
        end
        ivalid16 = 1'b0; clear16 = 1'b0; last16 = 1'b0;
        n = 0;
        while (!ovalid16 && n < 20) begin @(negedge clock); n++; end
        checks++;
        if (ovalid16 !== 1'b1 || result16 !== want) begin
            errors++; $display("FAIL overflow: ovalid=%b result=%h want %h", ovalid16, result16, want);
        end
        idle(1);
        dataa16 = {8'd0, 8'd0, 8'd0, 8'd1}; datab16 = {4{8'd5}}; last16 = 1'b1; ivalid16 = 1'b1;
        idle(1);
        ivalid16 = 1'b0; last16 = 1'b0;
        n = 0;
        while (!ovalid16 && n < 20) begin @(negedge clock); n++; end
        checks++;
        if (ovalid16 !== 1'b1 || result16 !== 16'd5) begin
            errors++; $display("FAIL overflow_restart: ovalid=%b result=%h want 0005", ovalid16, result16);
        end
    endtask

    initial begin
        reset = 1'b1; ivalid = 1'b0; iready = 1'b1; dataa = '0; datab = '0;
        signed_mode = 1'b0; clear = 1'b0; last = 1'b0;
        ivalid16 = 1'b0; iready16 = 1'b1; dataa16 = '0; datab16 = '0;
        signed16 = 1'b0; clear16 = 1'b0; last16 = 1'b0;
        m_acc = 0;
        test_reset();
        test_single_signed();
        test_unsigned_group();
        test_backpressure();
        test_bubbles();
        test_reset_mid_group();
        test_random();
        test_overflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_lanes_accum.md
Name: mac_lanes_accum

Overview:
Parametrised multi-lane multiply-accumulate engine for the PE dot-product path. Each beat takes NUM_LANES operand pairs, multiplies them, reduces them through an adder tree and folds the sum into a running accumulator. One result is emitted per accumulation group, framed by clear/last. Uses the OpenCL HDL-library handshake (ivalid/oready upstream, ovalid/iready downstream) with full backpressure.

Parameters:
NUM_LANES, 4, operand pairs per beat; power of 2, 1..16
IN_WIDTH, 8, bits per operand
ACC_WIDTH, 32, output result width; must be >= 2*IN_WIDTH+log2(NUM_LANES)
GUARD_BITS, 8, extra internal accumulator bits above ACC_WIDTH

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
ivalid  in  1  input beat valid
oready  out  1  block can accept a beat this cycle
dataa  in  NUM_LANES*IN_WIDTH  lane operands A, lane i at bits [i*IN_WIDTH +: IN_WIDTH]
datab  in  NUM_LANES*IN_WIDTH  lane operands B, same packing
signed_mode  in  1  1: operands two's complement; 0: unsigned
clear  in  1  beat is the first of a group; the accumulator restarts from 0
last  in  1  beat closes the group; emit the result
ovalid  out  1  result valid
iready  in  1  downstream accepts the result
result  out  ACC_WIDTH  accumulated group result, sign-extended/clamped per mode

Behaviour:
- Reset (async assert, sync release): all stage valids 0, accumulator 0, ovalid 0, result 0. Reset mid-group discards the partial sum.
- Pipeline: S1 registers operands, mode, clear and last, and forms NUM_LANES products of 2*IN_WIDTH+1 bits; the extra bit gives a uniform signed representation. S2 is the adder tree, registered. S3 holds the accumulator and output register.
- Latency: a beat accepted in cycle t with last=1 gives ovalid=1 in cycle t+3 when there is no stall.
- Advance enable: en = ~ovalid | iready. oready = en. A beat is accepted when ivalid & oready. All stages hold when en=0; data and valids are frozen. Bubbles (stage valid=0) advance but do not touch the accumulator.
- ovalid/result hold steady until iready=1. ovalid drops on the handshake cycle unless a new last beat lands in the same cycle; back-to-back results are allowed.
- Accumulate in S3 on a valid beat: acc_next = (clear ? 0 : acc) + tree_sum. Width is ACC_WIDTH+GUARD_BITS, signed.
- If last: result <= convert(acc_next), ovalid <= 1, acc <= 0. Otherwise acc <= acc_next.
- clear=1 and last=1 on the same beat: a single-beat group; result = that beat's tree sum.
- last without a preceding clear continues from the current acc. After any last, acc is already 0.
- signed_mode is sampled per beat; mixing modes within a group is legal, with products summed as signed values.
- convert() without saturation: take the low ACC_WIDTH bits (wrap).

Optional Feature:
MAC_SATURATE_EN
- Defined: convert() clamps acc_next to the signed ACC_WIDTH range [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. The guard bits also saturate internally, so the accumulator never wraps: acc_next is clamped to the ACC_WIDTH+GUARD_BITS range. No extra latency.
- Undefined: convert() truncates (wrap) and there is no internal clamping. Port list is identical in both builds.

Test Plan:
- Reset/idle: assert reset for 3 cycles -> ovalid=0, result=0, oready=1 once released with iready=1.
- Single signed beat: signed_mode=1, A={1,2,3,4}, B={-1,-1,-1,-1}, clear=last=1 -> ovalid 3 cycles later, result=-10 (0xFFFFFFF6).
- Unsigned group: three beats of A=B={255,255,255,255}, clear on beat 1, last on beat 3 -> result=780300. Next group starts from 0.
- Backpressure: iready=0 while a result is pending and 2 more last beats are issued -> oready drops to 0 and result stays constant. Releasing iready yields results in order with no loss or duplication.
- Bubbles/reset mid-group: ivalid gaps inside a group -> same sum as without gaps. reset pulse after beat 2 of 3 -> no ovalid, next group's result excludes the prior partial.
- Overflow (ACC_WIDTH=16, signed, A=B={127,...}, 20 beats, sum 1290320): with MAC_SATURATE_EN result=32767; without it result=low 16 bits of 1290320 = 0xB050 (-20400).
